operand_issue: RTL and testbench
================================

Name: operand_issue

Overview:
- Stage directly upstream of the ALU.
- Accepts instruction words from fetch over a valid/ready handshake and decodes them.
- Reads operands from an internal 8-entry register file and drives the ALU opcode, dest, op1, op2 and cin inputs with a one-cycle alu_en pulse per issue.
- Owns the architectural register file and flag register, which are written back from the ALU's dest_out/result/flags. A scoreboard stalls issue on RAW/WAW/flag hazards.

Parameters:
WIDTH, 32, datapath width
INSTR_W, 16, instruction word width
OPCODE, 4, opcode field width
REGS_CODING, 3, register index width (2**REGS_CODING registers)
FLAGS, 4, flag vector width
CARRY, 0, carry bit index within flags
MAX_OUT, 3, maximum in-flight (issued, not written back) operations

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
instr_valid  in  1  fetch presents instr
instr  in  INSTR_W  instruction word
instr_ready  out  1  stage accepts instr this cycle
alu_en  out  1  one-cycle issue strobe to ALU en
alu_opcode  out  OPCODE  to ALU opcode
alu_dest  out  REGS_CODING  to ALU dest_in
alu_op1  out  WIDTH  to ALU op1
alu_op2  out  WIDTH  to ALU op2
alu_cin  out  1  to ALU cin
wb_valid  in  1  ALU writeback strobe
wb_dest  in  REGS_CODING  from ALU dest_out
wb_result  in  WIDTH  from ALU result
wb_flags  in  FLAGS  from ALU flags
flags_q  out  FLAGS  architectural flag register
busy  out  1  in-flight count nonzero

Behaviour:
- Clock port is clk. Reset port is rst_n: synchronous, active low, sampled on the rising edge of clk.
- Reset values: all registers 0, flags_q 0, scoreboard clear, in-flight count 0. Outputs alu_en, alu_opcode, alu_dest, alu_op1, alu_op2 and alu_cin are all 0; busy 0.
- Instruction decode:
  - [15:12] opcode, [11:9] dest, [8:6] src1, [5] imm.
  - imm=0: src2 = [4:2].
  - imm=1: op2 = zero-extended [4:0].
- Carry-use opcodes are 4'h2 (ADC) and 4'h3 (SBC); these take alu_cin = carry flag. All other opcodes drive alu_cin 0.
- Scoreboard:
  - pending[i] is set on issue of dest i and cleared on wb_valid with wb_dest i.
  - Every issue writes flags, so flag hazard = in-flight count > 0.
- Issue condition, all of the following must hold:
  - instr_valid.
  - pending[src1] not set.
  - pending[src2] not set (only when imm=0).
  - pending[dest] not set.
  - If carry-use opcode: in-flight count == 0.
  - In-flight count < MAX_OUT.
- instr_ready is combinational and equals the issue condition with instr_valid removed. A transfer occurs when instr_valid && instr_ready.
- Hazard evaluation with bypass: evaluate hazards after applying the same-cycle writeback.
  - A wb_valid clearing pending[x] in cycle N lets an instruction reading x issue in cycle N.
  - Its operand takes wb_result, not the stale register value.
  - Carry likewise bypasses from wb_flags[CARRY] when wb_valid and the count drops to 0 in that cycle.
- Issue registering: on transfer, the ALU outputs are registered, so alu_en is high in cycle N+1 for one cycle. The outputs hold their last values while alu_en is low.
- Writeback: on wb_valid, regs[wb_dest] <= wb_result and flags_q <= wb_flags, both in the same cycle.
- In-flight count:
  - +1 on transfer, -1 on wb_valid.
  - Unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUT; never underflows.
- Protocol violations:
  - wb_valid with count 0 is ignored for the count but still writes the register.
  - Issuing dest x while pending[x] is set cannot happen (WAW stall).
- Simultaneous set/clear: when a transfer sets pending[x] and a wb_valid clears pending[x] in the same cycle, the set takes priority.
- Back-to-back independent operations issue every cycle up to MAX_OUT in flight.
- busy = (in-flight count != 0).
- Reset mid-operation clears the scoreboard, count and registers. Any writeback arriving after reset is still applied to the register file, without count underflow.

Decomposition:
- Shared package holds:
  - opcode constants (ADC=4'h2, SBC=4'h3) and an is_carry_op function;
  - instruction field bit positions;
  - flag indices CARRY/SIGN/OVERFLOW/ZERO, shared with the ALU.
- One sub-module, regfile_2r1w: 8 x WIDTH storage with two combinational read ports, one synchronous write port, synchronous active-low clear, and write-to-read bypass.

Test Plan:
- Reset then readback: rst_n=0 for 2 cycles, then issue ADD r1=r0+r0. Expect alu_op1=alu_op2=0, alu_cin=0, alu_en high exactly 1 cycle after the transfer.
- Immediate: instr opcode 1, dest 2, src1 0, imm=1, imm5=5'd17. Expect alu_op2=32'd17, alu_dest=2.
- RAW stall and bypass:
  - Issue r3=...; the next instruction reads r3, so instr_ready=0 while r3 is pending.
  - Drive wb_valid, wb_dest=3, wb_result=32'hDEADBEEF.
  - Expect instr_ready=1 that same cycle and alu_op1=32'hDEADBEEF next cycle.
- Carry: with one op in flight, present ADC. Expect instr_ready=0 until wb_valid with wb_flags=4'b0001, then issue with alu_cin=1; flags_q=4'b0001 after writeback.
- Throughput limit: 4 independent ops with dests 1..4 and no writeback. Expect 3 issues on consecutive cycles, then instr_ready=0 with busy=1. One writeback releases the 4th.
- Reset mid-flight: 2 ops in flight, assert rst_n=0 for 1 cycle. Expect busy=0, instr_ready=1, and register reads return 0.

Source files
------------

// File: rtl/operand_issue_pkg.sv
// Shared definitions for the operand issue stage and the ALU it feeds:
// opcode constants, instruction field positions and flag bit indices.
package operand_issue_pkg;

   localparam logic [3:0] OP_ADC = 4'h2;
   localparam logic [3:0] OP_SBC = 4'h3;

   localparam int OPC_LSB  = 12;
   localparam int DEST_LSB = 9;
   localparam int SRC1_LSB = 6;
   localparam int IMM_BIT  = 5;
   localparam int SRC2_LSB = 2;
   localparam int IMM5_LSB = 0;

   localparam int OPC_W  = 4;
   localparam int REG_W  = 3;
   localparam int IMM5_W = 5;

   localparam int FLAG_CARRY    = 0;
   localparam int FLAG_SIGN     = 1;
   localparam int FLAG_OVERFLOW = 2;
   localparam int FLAG_ZERO     = 3;

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [REG_W-1:0]  dest;
      logic [REG_W-1:0]  src1;
      logic [REG_W-1:0]  src2;
      logic              imm;
      logic [IMM5_W-1:0] imm5;
   } decoded_t;

   function automatic logic is_carry_op(input logic [OPC_W-1:0] opc);
      return (opc == OP_ADC) || (opc == OP_SBC);
   endfunction

   // src2 and imm5 overlap; the imm bit decides which one is meaningful.
   function automatic decoded_t decode(input logic [15:0] word);
      decoded_t d;
      d.opcode = word[OPC_LSB  +: OPC_W];
      d.dest   = word[DEST_LSB +: REG_W];
      d.src1   = word[SRC1_LSB +: REG_W];
      d.src2   = word[SRC2_LSB +: REG_W];
      d.imm    = word[IMM_BIT];
      d.imm5   = word[IMM5_LSB +: IMM5_W];
      return d;
   endfunction

endpackage

// File: rtl/operand_issue_regfile_2r1w.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, synchronous active-low clear, and write-to-read bypass.
module regfile_2r1w #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [WIDTH-1:0]  rdata1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [WIDTH-1:0]  rdata2
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // A reader in the same cycle as the write sees the new value.
   assign rdata1 = (we && (waddr == raddr1)) ? wdata : mem[raddr1];
   assign rdata2 = (we && (waddr == raddr2)) ? wdata : mem[raddr2];

endmodule

// File: rtl/operand_issue.sv
// Issue stage ahead of the ALU: decodes instructions, reads operands, tracks
// in-flight destinations and stalls on RAW/WAW/flag hazards.
module operand_issue
   import operand_issue_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int INSTR_W     = 16,
   parameter int OPCODE      = 4,
   parameter int REGS_CODING = 3,
   parameter int FLAGS       = 4,
   parameter int CARRY       = FLAG_CARRY,
   parameter int MAX_OUT     = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   instr_valid,
   input  logic [INSTR_W-1:0]     instr,
   output logic                   instr_ready,
   output logic                   alu_en,
   output logic [OPCODE-1:0]      alu_opcode,
   output logic [REGS_CODING-1:0] alu_dest,
   output logic [WIDTH-1:0]       alu_op1,
   output logic [WIDTH-1:0]       alu_op2,
   output logic                   alu_cin,
   input  logic                   wb_valid,
   input  logic [REGS_CODING-1:0] wb_dest,
   input  logic [WIDTH-1:0]       wb_result,
   input  logic [FLAGS-1:0]       wb_flags,
   output logic [FLAGS-1:0]       flags_q,
   output logic                   busy
);

   localparam int NREGS = 2 ** REGS_CODING;
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   decoded_t         dec;
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_eff;
   logic [NREGS-1:0] wb_mask;
   logic [NREGS-1:0] issue_mask;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_eff;
   logic             wb_counts;
   logic             carry_op;
   logic             transfer;
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;
   logic [WIDTH-1:0] op2_next;
   logic             cin_next;

   assign dec      = decode(instr);
   assign carry_op = is_carry_op(dec.opcode);

   // Hazards are judged against the scoreboard as it looks after this
   // cycle's writeback, so a retiring producer releases its consumer at once.
   always_comb begin
      wb_mask = '0;
      if (wb_valid) begin
         wb_mask[wb_dest] = 1'b1;
      end
      pending_eff = pending & ~wb_mask;
      wb_counts   = wb_valid && (count != '0);
      count_eff   = count - {{(CNT_W-1){1'b0}}, wb_counts};
      instr_ready = !pending_eff[dec.src1]
                 && (dec.imm || !pending_eff[dec.src2])
                 && !pending_eff[dec.dest]
                 && (!carry_op || (count_eff == '0))
                 && (count_eff < CNT_W'(MAX_OUT));
   end

   assign transfer = instr_valid && instr_ready;

   always_comb begin
      issue_mask = '0;
      if (transfer) begin
         issue_mask[dec.dest] = 1'b1;
      end
   end

   regfile_2r1w #(
      .WIDTH  (WIDTH),
      .ADDR_W (REGS_CODING)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wb_valid),
      .waddr  (wb_dest),
      .wdata  (wb_result),
      .raddr1 (dec.src1),
      .rdata1 (rd1),
      .raddr2 (dec.src2),
      .rdata2 (rd2)
   );

   assign op2_next = dec.imm ? WIDTH'(dec.imm5) : rd2;
   assign cin_next = carry_op && (wb_valid ? wb_flags[CARRY] : flags_q[CARRY]);

   // A new issue to x wins over a retiring writeback to x in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
         count   <= '0;
      end else begin
         pending <= pending_eff | issue_mask;
         case ({transfer, wb_counts})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else if (wb_valid) begin
         flags_q <= wb_flags;
      end
   end

   // ALU inputs are registered and hold between issues.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_en     <= 1'b0;
         alu_opcode <= '0;
         alu_dest   <= '0;
         alu_op1    <= '0;
         alu_op2    <= '0;
         alu_cin    <= 1'b0;
      end else begin
         alu_en <= transfer;
         if (transfer) begin
            alu_opcode <= dec.opcode;
            alu_dest   <= dec.dest;
            alu_op1    <= rd1;
            alu_op2    <= op2_next;
            alu_cin    <= cin_next;
         end
      end
   end

   assign busy = (count != '0);

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed scenarios followed by random traffic, all
// checked against a queue-based model of in-flight destinations.
module tb_operand_issue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_ready;
   logic        alu_en;
   logic [3:0]  alu_opcode;
   logic [2:0]  alu_dest;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic        alu_cin;
   logic        wb_valid = 1'b0;
   logic [2:0]  wb_dest = '0;
   logic [31:0] wb_result = '0;
   logic [3:0]  wb_flags = '0;
   logic [3:0]  flags_q;
   logic        busy;

   operand_issue dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .alu_en      (alu_en),
      .alu_opcode  (alu_opcode),
      .alu_dest    (alu_dest),
      .alu_op1     (alu_op1),
      .alu_op2     (alu_op2),
      .alu_cin     (alu_cin),
      .wb_valid    (wb_valid),
      .wb_dest     (wb_dest),
      .wb_result   (wb_result),
      .wb_flags    (wb_flags),
      .flags_q     (flags_q),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   logic [31:0] m_regs [8];
   logic [3:0]  m_flags;
   logic [2:0]  m_q [$];
   logic [3:0]  e_opc;
   logic [2:0]  e_dest;
   logic [31:0] e_op1;
   logic [31:0] e_op2;
   logic        e_cin;
   logic        last_ready;
   logic        iss;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic [3:0] o, input logic [2:0] d,
                                      input logic [2:0] s1, input logic [2:0] s2);
      return {o, d, s1, 1'b0, s2, 2'b00};
   endfunction

   function automatic logic [15:0] mk_imm(input logic [3:0] o, input logic [2:0] d,
                                          input logic [2:0] s1, input logic [4:0] imm5);
      return {o, d, s1, 1'b1, imm5};
   endfunction

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      instr_valid = 1'b0;
      wb_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
      foreach (m_regs[i]) m_regs[i] = '0;
      m_flags = '0;
      m_q.delete();
      e_opc = '0; e_dest = '0; e_op1 = '0; e_op2 = '0; e_cin = 1'b0;
   endtask

   // One clock of traffic: predicts readiness and issued operands from the
   // architectural state with this cycle's writeback applied first.
   task automatic apply_stimulus(input logic v, input logic [15:0] ins, input logic wv,
                                 input logic [2:0] wd, input logic [31:0] wr,
                                 input logic [3:0] wf, output logic issued);
      logic [3:0]  opc;
      logic [2:0]  d, s1, s2;
      logic        im, carry, hit1, hit2, hitd, exp_ready;
      logic [31:0] r_eff [8];
      logic [3:0]  f_eff;
      logic [2:0]  q_eff [$];
      opc = ins[15:12]; d = ins[11:9]; s1 = ins[8:6]; im = ins[5]; s2 = ins[4:2];
      r_eff = m_regs;
      if (wv) r_eff[wd] = wr;
      f_eff = wv ? wf : m_flags;
      q_eff = m_q;
      if (wv) begin
         for (int i = 0; i < q_eff.size(); i++) begin
            if (q_eff[i] == wd) begin
               q_eff.delete(i);
               break;
            end
         end
      end
      hit1 = 1'b0; hit2 = 1'b0; hitd = 1'b0;
      foreach (q_eff[i]) begin
         if (q_eff[i] == s1) hit1 = 1'b1;
         if (q_eff[i] == s2) hit2 = 1'b1;
         if (q_eff[i] == d)  hitd = 1'b1;
      end
      carry = (opc == 4'h2) || (opc == 4'h3);
      exp_ready = !hit1 && (im || !hit2) && !hitd
               && (!carry || q_eff.size() == 0) && (q_eff.size() < 3);
      instr_valid = v; instr = ins;
      wb_valid = wv; wb_dest = wd; wb_result = wr; wb_flags = wf;
      #1;
      last_ready = instr_ready;
      check_output("instr_ready", {31'b0, instr_ready}, {31'b0, exp_ready});
      @(posedge clk);
      #1;
      issued = v && exp_ready;
      if (issued) begin
         e_opc = opc; e_dest = d; e_op1 = r_eff[s1];
         e_op2 = im ? {27'b0, ins[4:0]} : r_eff[s2];
         e_cin = carry ? f_eff[0] : 1'b0;
         q_eff.push_back(d);
      end
      m_regs = r_eff; m_flags = f_eff; m_q = q_eff;
      check_output("alu_en", {31'b0, alu_en}, {31'b0, issued});
      check_output("alu_opcode", {28'b0, alu_opcode}, {28'b0, e_opc});
      check_output("alu_dest", {29'b0, alu_dest}, {29'b0, e_dest});
      check_output("alu_op1", alu_op1, e_op1);
      check_output("alu_op2", alu_op2, e_op2);
      check_output("alu_cin", {31'b0, alu_cin}, {31'b0, e_cin});
      check_output("busy", {31'b0, busy}, {31'b0, (m_q.size() != 0)});
      check_output("flags_q", {28'b0, flags_q}, {28'b0, m_flags});
      instr_valid = 1'b0;
      wb_valid = 1'b0;
   endtask

   task automatic drain();
      logic i_unused;
      while (m_q.size() > 0) begin
         apply_stimulus(1'b0, '0, 1'b1, m_q[0], $urandom, 4'($urandom_range(0, 15)), i_unused);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] rins;
      logic        rv, rwv;
      logic [2:0]  rwd;
      do_reset(2);
      check_output("rst_alu_en", {31'b0, alu_en}, 32'd0);
      check_output("rst_op1", alu_op1, 32'd0);
      check_output("rst_op2", alu_op2, 32'd0);
      check_output("rst_cin", {31'b0, alu_cin}, 32'd0);
      check_output("rst_busy", {31'b0, busy}, 32'd0);
      check_output("rst_flags", {28'b0, flags_q}, 32'd0);

      $display("[TB] reset then ADD r1=r0+r0");
      apply_stimulus(1'b1, mk(4'h1, 3'd1, 3'd0, 3'd0), 1'b0, '0, '0, '0, iss);
      check_output("t1_en", {31'b0, alu_en}, 32'd1);
      check_output("t1_op1", alu_op1, 32'd0);
      check_output("t1_op2", alu_op2, 32'd0);
      check_output("t1_cin", {31'b0, alu_cin}, 32'd0);
      apply_stimulus(1'b0, '0, 1'b0, '0, '0, '0, iss);
      check_output("t1_en_pulse", {31'b0, alu_en}, 32'd0);

      $display("[TB] immediate operand");
      apply_stimulus(1'b1, mk_imm(4'h1, 3'd2, 3'd0, 5'd17), 1'b0, '0, '0, '0, iss);
      check_output("t2_op2", alu_op2, 32'd17);
      check_output("t2_dest", {29'b0, alu_dest}, 32'd2);
      drain();

      $display("[TB] RAW stall and bypass");
      apply_stimulus(1'b1, mk(4'h1, 3'd3, 3'd0, 3'd0), 1'b0, '0, '0, '0, iss);
      apply_stimulus(1'b1, mk(4'h1, 3'd4, 3'd3, 3'd0), 1'b0, '0, '0, '0, iss);
      check_output("t3_stall", {31'b0, last_ready}, 32'd0);
      apply_stimulus(1'b1, mk(4'h1, 3'd4, 3'd3, 3'd0), 1'b1, 3'd3, 32'hDEADBEEF, 4'h0, iss);
      check_output("t3_release", {31'b0, last_ready}, 32'd1);
      check_output("t3_op1", alu_op1, 32'hDEADBEEF);
      drain();

      $display("[TB] carry hazard");
      apply_stimulus(1'b1, mk(4'h1, 3'd5, 3'd0, 3'd0), 1'b0, '0, '0, '0, iss);
      repeat (2) apply_stimulus(1'b1, mk(4'h2, 3'd6, 3'd0, 3'd0), 1'b0, '0, '0, '0, iss);
      check_output("t4_stall", {31'b0, last_ready}, 32'd0);
      apply_stimulus(1'b1, mk(4'h2, 3'd6, 3'd0, 3'd0), 1'b1, 3'd5, 32'h5, 4'b0001, iss);
      check_output("t4_release", {31'b0, last_ready}, 32'd1);
      check_output("t4_cin", {31'b0, alu_cin}, 32'd1);
      check_output("t4_flags", {28'b0, flags_q}, 32'd1);
      drain();

      $display("[TB] throughput limit");
      for (int d = 1; d <= 3; d++) begin
         apply_stimulus(1'b1, mk_imm(4'h1, 3'(d), 3'd0, 5'(d)), 1'b0, '0, '0, '0, iss);
         check_output("t5_issue", {31'b0, alu_en}, 32'd1);
      end
      apply_stimulus(1'b1, mk_imm(4'h1, 3'd4, 3'd0, 5'd4), 1'b0, '0, '0, '0, iss);
      check_output("t5_full", {31'b0, last_ready}, 32'd0);
      check_output("t5_busy", {31'b0, busy}, 32'd1);
      apply_stimulus(1'b1, mk_imm(4'h1, 3'd4, 3'd0, 5'd4), 1'b1, 3'd1, 32'h77, 4'h0, iss);
      check_output("t5_fourth", {31'b0, alu_en}, 32'd1);
      check_output("t5_dest", {29'b0, alu_dest}, 32'd4);
      drain();

      $display("[TB] reset mid-flight");
      apply_stimulus(1'b0, '0, 1'b1, 3'd1, 32'h1111, 4'h0, iss);
      apply_stimulus(1'b0, '0, 1'b1, 3'd2, 32'h2222, 4'h0, iss);
      apply_stimulus(1'b1, mk(4'h1, 3'd5, 3'd1, 3'd2), 1'b0, '0, '0, '0, iss);
      check_output("t6_pre_op1", alu_op1, 32'h1111);
      apply_stimulus(1'b1, mk(4'h1, 3'd6, 3'd1, 3'd2), 1'b0, '0, '0, '0, iss);
      do_reset(1);
      check_output("t6_busy", {31'b0, busy}, 32'd0);
      apply_stimulus(1'b1, mk(4'h1, 3'd7, 3'd1, 3'd2), 1'b0, '0, '0, '0, iss);
      check_output("t6_ready", {31'b0, last_ready}, 32'd1);
      check_output("t6_op1", alu_op1, 32'd0);
      check_output("t6_op2", alu_op2, 32'd0);
      drain();
      apply_stimulus(1'b0, '0, 1'b1, 3'd3, 32'hCAFE, 4'h0, iss);
      check_output("t6_no_underflow", {31'b0, busy}, 32'd0);
      apply_stimulus(1'b1, mk(4'h1, 3'd1, 3'd3, 3'd3), 1'b0, '0, '0, '0, iss);
      check_output("t6_late_wb", alu_op1, 32'hCAFE);
      drain();

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         rins = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rins[15:12] = 4'h2 + 4'($urandom_range(0, 1));
         rv  = ($urandom_range(0, 9) < 7);
         rwv = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
         rwd = rwv ? m_q[$urandom_range(0, m_q.size() - 1)] : 3'($urandom);
         apply_stimulus(rv, rins, rwv, rwd, $urandom, 4'($urandom), iss);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
